// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial LSB-first adder sequencer with valid/ready handshakes
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             accept;
    logic             last_bit;
    logic             bit_s;
    logic             bit_c;

    // One full-adder slice working on the current LSBs and the carry flop
    assign bit_s    = a_sr[0] ^ b_sr[0] ^ carry;
    assign bit_c    = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & carry);
    assign last_bit = (cnt == LAST);

    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs; flush overrides every transition including acceptance
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    accept   = 1'b1;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (flush) begin
            state_nx = S_IDLE;
        end
    end

    // Datapath: operand load, per-bit shift/accumulate, result capture on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (flush) begin
            // Result registers deliberately keep whatever they held
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            sum_r <= (sum_r >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
            carry <= bit_c;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                cout_r <= bit_c;
                ovf_r  <= carry ^ bit_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - table-driven and directed checks for serial_adder_ctrl (WIDTH 8 and 1)
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       busy;

    logic       flush1 = 1'b0;
    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic       out_valid1;
    logic       out_ready1 = 1'b0;
    logic [0:0] sum1;
    logic       cout1;
    logic       ovf1;
    logic       busy1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
    );

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vcin;
        logic [7:0] esum;
        logic       ecout;
        logic       eovf;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Present operands for one cycle; returns with inputs deasserted, one negedge after acceptance
    task automatic issue8(input logic [7:0] va, input logic [7:0] vb, input logic vc);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded
    task automatic wait_done8(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic consume8;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [7:0] hs;
        logic hc, ho;
        bit seen;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("v%0d_in_ready", i), in_ready, 1);
            issue8(vecs[i].va, vecs[i].vb, vecs[i].vcin);
            chk($sformatf("v%0d_busy", i), busy, 1);
            wait_done8(cyc);
            chk($sformatf("v%0d_latency", i), cyc, 8);
            chk($sformatf("v%0d_sum", i), sum, vecs[i].esum);
            chk($sformatf("v%0d_cout", i), cout, vecs[i].ecout);
            chk($sformatf("v%0d_ovf", i), ovf, vecs[i].eovf);
            consume8;
            chk($sformatf("v%0d_out_valid_fall", i), out_valid, 0);
            chk($sformatf("v%0d_idle_stale_sum", i), sum, vecs[i].esum);
        end

        // Backpressure: hold out_ready low for 5 cycles in DONE
        issue8(8'h5A, 8'h3C, 1'b0);
        wait_done8(cyc);
        hs = sum; hc = cout; ho = ovf;
        chk("hold_sum_first", hs, 8'h96);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_result", {sum, cout, ovf}, {8'h96, 1'b0, 1'b1});
        end
        consume8;

        // Operand pulse during RUN must be ignored
        issue8(8'h01, 8'h01, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("ign_in_ready_run", in_ready, 0);
        a = 8'h11; b = 8'h11; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_done8(cyc);
        chk("ign_sum", sum, 8'h02);
        chk("ign_cout", cout, 0);
        consume8;
        @(negedge clk);
        chk("ign_no_second_op", busy, 0);

        // Async reset at RUN cycle 3
        issue8(8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {in_ready, out_valid, busy, sum, cout, ovf}, {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_idle", {in_ready, busy}, {1'b1, 1'b0});

        // Flush at RUN cycle 3
        issue8(8'h5A, 8'h3C, 1'b0);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", {in_ready, busy}, {1'b1, 1'b0});
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("flush_no_out_valid", seen, 0);

        // Flush wins over acceptance in the same cycle
        a = 8'h01; b = 8'h02; cin = 1'b0; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_prio_busy", busy, 0);

        // After flush the engine still computes correctly (carry cleared)
        issue8(8'h7F, 8'h00, 1'b1);
        wait_done8(cyc);
        chk("post_flush_latency", cyc, 8);
        chk("post_flush_sum", {sum, cout, ovf}, {8'h80, 1'b0, 1'b1});
        consume8;

        // WIDTH=1: directed 1+1+1
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        cyc = 0;
        while (!out_valid1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("w1_latency", cyc, 1);
        chk("w1_result", {sum1, cout1, ovf1}, {1'b1, 1'b1, 1'b0});
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;

        // WIDTH=1: random operations against a+b+cin
        for (int n = 0; n < 1000; n++) begin
            logic ra, rb, rc;
            logic [1:0] tot;
            ra = 1'($urandom_range(1)); rb = 1'($urandom_range(1)); rc = 1'($urandom_range(1));
            tot = {1'b0, ra} + {1'b0, rb} + {1'b0, rc};
            a1 = ra; b1 = rb; cin1 = rc; in_valid1 = 1'b1;
            @(negedge clk);
            in_valid1 = 1'b0;
            cyc = 0;
            while (!out_valid1 && cyc < 10) begin
                @(negedge clk);
                cyc++;
            end
            chk("w1_rand", {cyc[3:0], cout1, sum1, ovf1}, {4'd1, tot[1], tot[0], rc ^ tot[1]});
            out_ready1 = 1'b1;
            @(negedge clk);
            out_ready1 = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
